tcm_dport_ctrl: RTL and testbench

TCM_DPORT_CTRL -- requirements
Module: tcm_dport_ctrl

---
 rtl/tcm_dport_ctrl_if.sv | 43 ++++
 rtl/tcm_dport_ctrl.sv | 118 +++++++++++
 tb/tb_tcm_dport_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_dport_ctrl_if.sv
// Data-port bundle between a CPU load/store unit, the TCM controller and its single-port RAM.
// slave = controller view, master = CPU/RAM environment view.
interface tcm_dport_ctrl_if #(
  parameter int RAM_AW = 15
);
  logic [31:0]       mem_d_addr_i;
  logic [31:0]       mem_d_data_wr_i;
  logic              mem_d_rd_i;
  logic [3:0]        mem_d_wr_i;
  logic              mem_d_cacheable_i;
  logic [10:0]       mem_d_req_tag_i;
  logic              mem_d_invalidate_i;
  logic              mem_d_writeback_i;
  logic              mem_d_flush_i;
  logic              mem_d_accept_o;
  logic              mem_d_ack_o;
  logic              mem_d_error_o;
  logic [10:0]       mem_d_resp_tag_o;
  logic [31:0]       mem_d_data_rd_o;
  logic              ram_busy_i;
  logic              ram_en_o;
  logic [3:0]        ram_wr_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;
  logic              init_done_o;

  modport slave (
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
           ram_busy_i, ram_rdata_i,
    output mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o,
           ram_en_o, ram_wr_o, ram_addr_o, ram_wdata_o, init_done_o
  );

  modport master (
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
           ram_busy_i, ram_rdata_i,
    input  mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o,
           ram_en_o, ram_wr_o, ram_addr_o, ram_wdata_o, init_done_o
  );
endinterface

// File: rtl/tcm_dport_ctrl.sv
// Tightly-coupled data memory controller: optional zero-fill, then 2-cycle fully pipelined loads/stores.
// Accept follows RAM availability each cycle; responses return exactly two cycles after accept, in order.
module tcm_dport_ctrl #(
  parameter int          RAM_AW    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter bit          INIT_EN   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tcm_dport_ctrl_if.slave  bus
);

  localparam int HI_LSB = RAM_AW + 2;
  localparam logic [RAM_AW-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [RAM_AW-1:0] init_cnt;

  logic        s1_vld;
  logic        s1_err;
  logic        s1_load;
  logic [10:0] s1_tag;

  logic        ack_q;
  logic        err_q;
  logic [10:0] tag_q;
  logic [31:0] data_q;

  logic in_run;
  logic in_init;
  logic is_req;
  logic is_store;
  logic is_load;
  logic hit;
  logic aligned;
  logic do_store;
  logic do_load;
  logic req_err;
  logic accept;
  logic take;
  logic unused_ok;

  assign unused_ok = bus.mem_d_cacheable_i;

  assign in_run  = (state == ST_RUN) && !rst_i;
  assign in_init = (state == ST_INIT) && !rst_i;

  // A store strobe wins over a simultaneous load; maintenance ops only need an ack.
  assign is_store = |bus.mem_d_wr_i;
  assign is_load  = bus.mem_d_rd_i && !is_store;
  assign is_req   = bus.mem_d_rd_i || is_store || bus.mem_d_invalidate_i ||
                    bus.mem_d_writeback_i || bus.mem_d_flush_i;
  assign hit      = (bus.mem_d_addr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign aligned  = (bus.mem_d_addr_i[1:0] == 2'b00);
  assign do_store = is_store && hit;
  assign do_load  = is_load && hit && aligned;
  assign req_err  = is_store ? !hit : (is_load && !(hit && aligned));

  assign accept = in_run && !bus.ram_busy_i;
  assign take   = accept && is_req;

  always_comb begin
    bus.ram_en_o    = 1'b0;
    bus.ram_wr_o    = 4'h0;
    bus.ram_addr_o  = bus.mem_d_addr_i[RAM_AW+1:2];
    bus.ram_wdata_o = bus.mem_d_data_wr_i;
    if (in_init) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_wr_o    = 4'hF;
      bus.ram_addr_o  = init_cnt;
      bus.ram_wdata_o = 32'h0;
    end else if (take && (do_store || do_load)) begin
      bus.ram_en_o = 1'b1;
      bus.ram_wr_o = do_store ? bus.mem_d_wr_i : 4'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_err   <= 1'b0;
      s1_load  <= 1'b0;
      s1_tag   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      if (state == ST_INIT && !bus.ram_busy_i) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end
      s1_vld  <= take;
      s1_err  <= take && req_err;
      s1_load <= take && do_load;
      s1_tag  <= take ? bus.mem_d_req_tag_i : 11'h0;
      // RAM read data is valid in the cycle after the enable, so it is captured here.
      ack_q   <= s1_vld;
      err_q   <= s1_vld && s1_err;
      tag_q   <= s1_vld ? s1_tag : 11'h0;
      data_q  <= (s1_vld && s1_load) ? bus.ram_rdata_i : 32'h0;
    end
  end

  assign bus.mem_d_accept_o   = accept;
  assign bus.mem_d_ack_o      = ack_q;
  assign bus.mem_d_error_o    = err_q;
  assign bus.mem_d_resp_tag_o = tag_q;
  assign bus.mem_d_data_rd_o  = data_q;
  assign bus.init_done_o      = in_run;

endmodule

// File: tb/tb_tcm_dport_ctrl.sv
// Scoreboarded bench: a byte-level memory model predicts every response, a monitor checks acks.
module tb_tcm_dport_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  tcm_dport_ctrl_if #(.RAM_AW(15)) bus ();
  tcm_dport_ctrl_if #(.RAM_AW(4))  bus1 ();

  tcm_dport_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  tcm_dport_ctrl #(.RAM_AW(4), .INIT_EN(1'b1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));

  typedef struct {
    int          due;
    logic [10:0] tag;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          busy_rand = 1'b0;
  logic [7:0]  ref_b[int];
  logic [31:0] ram [0:32767];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM behind the main controller: one-cycle read latency, unavailable while busy.
  always @(posedge clk) begin
    if (bus.ram_en_o && !bus.ram_busy_i) begin
      bus.ram_rdata_i <= ram[bus.ram_addr_o];
      if (bus.ram_wr_o != 4'h0)
        ram[bus.ram_addr_o] <= merge(ram[bus.ram_addr_o], bus.ram_wdata_o, bus.ram_wr_o);
    end else begin
      bus.ram_rdata_i <= $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    if (busy_rand) bus.ram_busy_i = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_d_ack_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_cycle", cyc, e.due);
          chk("resp_tag", bus.mem_d_resp_tag_o, e.tag);
          chk("resp_err", bus.mem_d_error_o, e.err);
          chk("resp_data", bus.mem_d_data_rd_o, e.data);
        end
      end else begin
        chk("idle_resp_zero", {bus.mem_d_error_o, bus.mem_d_resp_tag_o, bus.mem_d_data_rd_o}, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missing_ack", 0, 1);
          void'(exp_q.pop_front());
        end
      end
      if (bus.ram_busy_i && bus.ram_en_o) chk("ram_en_while_busy", 1, 0);
    end
  end

  task automatic idle_inputs();
    bus.mem_d_rd_i = 1'b0;
    bus.mem_d_wr_i = 4'h0;
    bus.mem_d_invalidate_i = 1'b0;
    bus.mem_d_writeback_i = 1'b0;
    bus.mem_d_flush_i = 1'b0;
    bus.mem_d_cacheable_i = $urandom_range(0, 1);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic [3:0] wr, input logic [2:0] mnt, input logic [10:0] tag);
    logic [31:0] off;
    logic        hit, st, ld, exp_en, err;
    logic [31:0] rdata;
    bit          acc;
    exp_t        e;
    bus.mem_d_addr_i = a;
    bus.mem_d_data_wr_i = d;
    bus.mem_d_rd_i = rd;
    bus.mem_d_wr_i = wr;
    {bus.mem_d_invalidate_i, bus.mem_d_writeback_i, bus.mem_d_flush_i} = mnt;
    bus.mem_d_req_tag_i = tag;
    off = a - 32'h80000000;
    hit = (off < 32'h00020000);
    st = (wr != 4'h0);
    ld = rd && !st;
    err = st ? !hit : (ld && !(hit && a[1:0] == 2'b00));
    exp_en = (st || ld) && !err;
    acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.mem_d_accept_o) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    chk("ram_en", bus.ram_en_o, exp_en);
    chk("ram_wr", bus.ram_wr_o, exp_en && st ? wr : 4'h0);
    if (exp_en) chk("ram_addr", bus.ram_addr_o, off >> 2);
    if (exp_en && st) chk("ram_wdata", bus.ram_wdata_o, d);
    rdata = 32'h0;
    for (int b = 0; b < 4; b++) begin
      int ba;
      ba = int'((off & 32'hFFFF_FFFC) + b);
      if (exp_en && st && wr[b]) ref_b[ba] = d[8*b +: 8];
      if (exp_en && ld) rdata[8*b +: 8] = ref_b.exists(ba) ? ref_b[ba] : 8'h00;
    end
    e.due = cyc + 2;
    e.tag = tag;
    e.err = err;
    e.data = rdata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    logic [31:0] a;
    int          k, idx;
    bit          done;
    exp_t        dropped;
    for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
    bus.mem_d_addr_i = 32'h0;
    bus.mem_d_data_wr_i = 32'h0;
    bus.mem_d_req_tag_i = 11'h0;
    bus.ram_busy_i = 1'b0;
    idle_inputs();
    bus1.mem_d_addr_i = 32'h0;
    bus1.mem_d_data_wr_i = 32'h0;
    bus1.mem_d_rd_i = 1'b0;
    bus1.mem_d_wr_i = 4'h0;
    bus1.mem_d_cacheable_i = 1'b0;
    bus1.mem_d_req_tag_i = 11'h0;
    bus1.mem_d_invalidate_i = 1'b0;
    bus1.mem_d_writeback_i = 1'b0;
    bus1.mem_d_flush_i = 1'b0;
    bus1.ram_busy_i = 1'b0;
    bus1.ram_rdata_i = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_accept", bus.mem_d_accept_o, 0);
    chk("rst_ack", bus.mem_d_ack_o, 0);
    chk("rst_err_tag_data", {bus.mem_d_error_o, bus.mem_d_resp_tag_o, bus.mem_d_data_rd_o}, 0);
    chk("rst_ram_en_wr", {bus.ram_en_o, bus.ram_wr_o}, 0);
    chk("rst_init_done", bus.init_done_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("run_init_done", bus.init_done_o, 1);
    chk("run_accept_idle", bus.mem_d_accept_o, 1);
    chk("run_ram_en_idle", bus.ram_en_o, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h80000100, 32'hDEADBEEF, 1'b0, 4'hF, 3'b000, 11'h005);
    issue(32'h80000100, 32'h0, 1'b1, 4'h0, 3'b000, 11'h006);
    issue(32'h80000100, 32'h0000AB00, 1'b0, 4'b0010, 3'b000, 11'h010);
    issue(32'h80000100, 32'h0, 1'b1, 4'h0, 3'b000, 11'h011);
    issue(32'h00001000, 32'h0, 1'b1, 4'h0, 3'b000, 11'h020);
    issue(32'h80000102, 32'h0, 1'b1, 4'h0, 3'b000, 11'h021);
    issue(32'h80000104, 32'h12345678, 1'b1, 4'hF, 3'b000, 11'h022);
    issue(32'h80000104, 32'h0, 1'b1, 4'h0, 3'b000, 11'h023);
    issue(32'h80000200, 32'h0, 1'b0, 4'h0, 3'b101, 11'h030);
    issue(32'h00000000, 32'h0, 1'b0, 4'h0, 3'b010, 11'h031);

    bus.ram_busy_i = 1'b1;
    bus.mem_d_addr_i = 32'h80000100;
    bus.mem_d_rd_i = 1'b1;
    bus.mem_d_req_tag_i = 11'h040;
    repeat (3) begin
      @(negedge clk);
      chk("busy_accept", bus.mem_d_accept_o, 0);
      chk("busy_ram_en", bus.ram_en_o, 0);
    end
    @(posedge clk);
    #1 bus.ram_busy_i = 1'b0;
    issue(32'h80000100, 32'h0, 1'b1, 4'h0, 3'b000, 11'h040);

    issue(32'h80000104, 32'h0, 1'b1, 4'h0, 3'b000, 11'h050);
    rst = 1'b1;
    dropped = exp_q.pop_back();
    @(negedge clk);
    chk("midrst_accept", bus.mem_d_accept_o, 0);
    chk("midrst_ram_en", bus.ram_en_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_accept", bus.mem_d_accept_o, 1);
    @(posedge clk);
    #1;
    issue(32'h80000104, 32'h0, 1'b1, 4'h0, 3'b000, dropped.tag + 11'h1);

    busy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: a = $urandom;
        1: a = 32'h8001FFFC;
        2: a = 32'h80020000;
        3: a = 32'h7FFFFFFC;
        default: a = 32'h80000000 + 32'($urandom_range(0, 63) << 2) +
                     (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      endcase
      k = $urandom_range(0, 9);
      if (k <= 3)      issue(a, $urandom, 1'b1, 4'h0, 3'b000, 11'($urandom));
      else if (k <= 6) issue(a, $urandom, 1'b0, 4'($urandom_range(1, 15)), 3'b000, 11'($urandom));
      else if (k == 7) issue(a, $urandom, 1'b1, 4'($urandom_range(1, 15)), 3'b000, 11'($urandom));
      else if (k == 8) issue(a, $urandom, 1'b0, 4'h0, 3'($urandom_range(1, 7)), 11'($urandom));
      else             issue(a, $urandom, 1'b1, 4'h0, 3'($urandom_range(1, 7)), 11'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    busy_rand = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);

    @(posedge clk);
    #1 rst1 = 1'b0;
    idx = 0;
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus1.init_done_o) begin
        done = 1'b1;
        break;
      end
      chk("init_accept", bus1.mem_d_accept_o, 0);
      chk("init_en", bus1.ram_en_o, 1);
      if (!bus1.ram_busy_i) begin
        chk("init_addr", bus1.ram_addr_o, idx);
        chk("init_wr", bus1.ram_wr_o, 4'hF);
        chk("init_wdata", bus1.ram_wdata_o, 0);
        idx++;
      end
      @(posedge clk);
      #1 bus1.ram_busy_i = (n == 6);
    end
    chk("init_done", done, 1);
    chk("init_write_count", idx, 16);
    chk("init_run_accept", bus1.mem_d_accept_o, 1);
    chk("init_run_ram_en", bus1.ram_en_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
